// File: rtl/matrix_stream_out_if.sv
// Valid/ready beat stream carrying one matrix element, its indices and framing flags.
interface matrix_stream_out_if #(
  parameter int ELEM_W = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic [2:0]        out_row;
  logic [2:0]        out_col;
  logic              out_hdr;
  logic              out_last;

  modport master (
    output out_valid, out_data, out_row, out_col, out_hdr, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_hdr, out_last,
    output out_ready
  );
endinterface

// File: rtl/matrix_stream_out.sv
// Streams the active m x n elements of a packed row-major matrix, one beat per cycle.
// Optional MATRIX_STREAM_HEADER_EN prepends a header beat carrying {n, m}.
module matrix_stream_out #(
  parameter int ELEM_W  = 8,
  parameter int MAX_DIM = 5
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [2:0]                        m,
  input  logic [2:0]                        n,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] matrix_in,
  output logic                              busy,
  output logic                              err,
  output logic                              done,
  matrix_stream_out_if.master               os
);

  localparam int         MAT_W   = MAX_DIM * MAX_DIM * ELEM_W;
  localparam int         IDX_W   = $clog2(MAT_W);
  localparam logic [2:0] DIM_MAX = 3'(MAX_DIM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    DONE   = 2'd2
`ifdef MATRIX_STREAM_HEADER_EN
    , HEADER = 2'd3
`endif
  } state_t;

  state_t             state_r, state_nxt;
  logic [MAT_W-1:0]   mat_r, mat_nxt;
  logic [2:0]         m_r, m_nxt, n_r, n_nxt;
  logic [2:0]         row_r, row_nxt, col_r, col_nxt;
  logic [2:0]         row_adv_s, col_adv_s;
  logic [ELEM_W-1:0]  data_r, data_nxt;
  logic               valid_r, valid_nxt;
  logic               hdr_r, hdr_nxt;
  logic               last_r, last_nxt;
  logic               busy_r, busy_nxt;
  logic               err_r, err_nxt;
  logic               done_r, done_nxt;
  logic               legal_s, xfer_s;

  function automatic logic [ELEM_W-1:0] elem_at(input logic [MAT_W-1:0] mat,
                                                input logic [2:0] r,
                                                input logic [2:0] c);
    logic [IDX_W-1:0] idx;
    idx = IDX_W'((int'(r) * MAX_DIM + int'(c)) * ELEM_W);
    return mat[idx +: ELEM_W];
  endfunction

  assign legal_s = (m != 3'd0) && (n != 3'd0) && (m <= DIM_MAX) && (n <= DIM_MAX);
  assign xfer_s  = valid_r && os.out_ready;

  // Row-major successor of the current beat position.
  always_comb begin
    row_adv_s = row_r;
    col_adv_s = col_r;
    if (col_r == n_r - 3'd1) begin
      row_adv_s = row_r + 3'd1;
      col_adv_s = 3'd0;
    end else begin
      col_adv_s = col_r + 3'd1;
    end
  end

  // Next-state and next registered-output values; everything holds unless a rule fires.
  always_comb begin
    state_nxt = state_r;
    mat_nxt   = mat_r;
    m_nxt     = m_r;
    n_nxt     = n_r;
    row_nxt   = row_r;
    col_nxt   = col_r;
    data_nxt  = data_r;
    valid_nxt = valid_r;
    hdr_nxt   = hdr_r;
    last_nxt  = last_r;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && legal_s) begin
          mat_nxt   = matrix_in;
          m_nxt     = m;
          n_nxt     = n;
          row_nxt   = 3'd0;
          col_nxt   = 3'd0;
          valid_nxt = 1'b1;
`ifdef MATRIX_STREAM_HEADER_EN
          state_nxt = HEADER;
          hdr_nxt   = 1'b1;
          data_nxt  = ELEM_W'({n, m});
          last_nxt  = 1'b0;
`else
          state_nxt = SEND;
          hdr_nxt   = 1'b0;
          data_nxt  = elem_at(matrix_in, 3'd0, 3'd0);
          last_nxt  = (m == 3'd1) && (n == 3'd1);
`endif
        end else if (start) begin
          err_nxt = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
`ifdef MATRIX_STREAM_HEADER_EN
      HEADER: begin
        if (xfer_s) begin
          state_nxt = SEND;
          hdr_nxt   = 1'b0;
          data_nxt  = elem_at(mat_r, 3'd0, 3'd0);
          last_nxt  = (m_r == 3'd1) && (n_r == 3'd1);
        end else begin
          state_nxt = HEADER;
        end
      end
`endif
      SEND: begin
        if (xfer_s && last_r) begin
          state_nxt = DONE;
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else if (xfer_s) begin
          row_nxt  = row_adv_s;
          col_nxt  = col_adv_s;
          data_nxt = elem_at(mat_r, row_adv_s, col_adv_s);
          last_nxt = (row_adv_s == m_r - 3'd1) && (col_adv_s == n_r - 3'd1);
        end else begin
          state_nxt = SEND;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        hdr_nxt   = 1'b0;
        last_nxt  = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers; reset wins over every other update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      mat_r   <= {MAT_W{1'b0}};
      m_r     <= 3'd0;
      n_r     <= 3'd0;
      row_r   <= 3'd0;
      col_r   <= 3'd0;
      data_r  <= {ELEM_W{1'b0}};
      valid_r <= 1'b0;
      hdr_r   <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      mat_r   <= mat_nxt;
      m_r     <= m_nxt;
      n_r     <= n_nxt;
      row_r   <= row_nxt;
      col_r   <= col_nxt;
      data_r  <= data_nxt;
      valid_r <= valid_nxt;
      hdr_r   <= hdr_nxt;
      last_r  <= last_nxt;
      busy_r  <= busy_nxt;
      err_r   <= err_nxt;
      done_r  <= done_nxt;
    end
  end

  assign busy         = busy_r;
  assign err          = err_r;
  assign done         = done_r;
  assign os.out_valid = valid_r;
  assign os.out_data  = data_r;
  assign os.out_row   = row_r;
  assign os.out_col   = col_r;
  assign os.out_hdr   = hdr_r;
  assign os.out_last  = last_r;

endmodule

// File: tb/tb_matrix_stream_out.sv
// Directed bench for matrix_stream_out: a queue model of expected beats checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_matrix_stream_out;

  typedef struct packed {
    logic       hdr;
    logic [7:0] data;
    logic [2:0] row;
    logic [2:0] col;
    logic       last;
  } beat_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   m;
  logic [2:0]   n;
  logic [199:0] matrix_in;
  logic         busy;
  logic         err;
  logic         done;

  int checks = 0;
  int errors = 0;

  beat_t      expq[$];
  logic [7:0] got[$];

  matrix_stream_out_if #(.ELEM_W(8)) os ();

  matrix_stream_out #(.ELEM_W(8), .MAX_DIM(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .m         (m),
    .n         (n),
    .matrix_in (matrix_in),
    .busy      (busy),
    .err       (err),
    .done      (done),
    .os        (os)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_elem(input int i, input int j, input logic [7:0] v);
    matrix_in[(i*5+j)*8 +: 8] = v;
  endtask

  // Model: the expected beat sequence is just the active region walked row-major.
  task automatic push_stream(input int mm, input int nn);
    beat_t b;
`ifdef MATRIX_STREAM_HEADER_EN
    b.hdr = 1'b1; b.data = 8'(nn * 8 + mm); b.row = 3'd0; b.col = 3'd0; b.last = 1'b0;
    expq.push_back(b);
`endif
    for (int i = 0; i < mm; i++) begin
      for (int j = 0; j < nn; j++) begin
        b.hdr  = 1'b0;
        b.data = matrix_in[(i*5+j)*8 +: 8];
        b.row  = 3'(i);
        b.col  = 3'(j);
        b.last = (i == mm - 1) && (j == nn - 1);
        expq.push_back(b);
      end
    end
  endtask

  // Compare every presented beat against the head of the expected queue.
  always @(negedge clk) begin
    beat_t e;
    if (reset === 1'b0 && os.out_valid === 1'b1) begin
      if (expq.size() == 0) begin
        chk("spurious_beat", {31'd0, os.out_valid}, 32'd0);
      end else begin
        e = expq[0];
        chk("beat_data", {24'd0, os.out_data}, {24'd0, e.data});
        chk("beat_row",  {29'd0, os.out_row},  {29'd0, e.row});
        chk("beat_col",  {29'd0, os.out_col},  {29'd0, e.col});
        chk("beat_last", {31'd0, os.out_last}, {31'd0, e.last});
        chk("beat_hdr",  {31'd0, os.out_hdr},  {31'd0, e.hdr});
        if (os.out_ready === 1'b1) begin
          if (!e.hdr) got.push_back(os.out_data);
          void'(expq.pop_front());
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},  {31'd0, busy},         32'd0);
    chk({tag, "_err"},   {31'd0, err},          32'd0);
    chk({tag, "_done"},  {31'd0, done},         32'd0);
    chk({tag, "_valid"}, {31'd0, os.out_valid}, 32'd0);
    chk({tag, "_data"},  {24'd0, os.out_data},  32'd0);
    chk({tag, "_row"},   {29'd0, os.out_row},   32'd0);
    chk({tag, "_col"},   {29'd0, os.out_col},   32'd0);
    chk({tag, "_hdr"},   {31'd0, os.out_hdr},   32'd0);
    chk({tag, "_last"},  {31'd0, os.out_last},  32'd0);
  endtask

  task automatic do_start(input logic [2:0] mm, input logic [2:0] nn);
    start = 1'b1;
    m     = mm;
    n     = nn;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drive out_ready by pattern until done pulses (bounded); mode 1 = 1,0,0 repeating.
  task automatic wait_done(input int mode, input bit inject);
    bit seen     = 1'b0;
    bit injected = 1'b0;
    int step     = 1;
    int k        = 0;
    while (!seen && k < 300) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(posedge clk); #1;
        os.out_ready = (mode == 1) ? (step % 3 == 0) : 1'b1;
        step++;
        if (inject && !injected && got.size() >= 7) begin
          start = 1'b1; m = 3'd2; n = 3'd2; matrix_in = ~matrix_in;
          injected = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    chk("queue_drained", expq.size(), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("valid_after", {31'd0, os.out_valid}, 32'd0);
    os.out_ready = 1'b1;
  endtask

  initial begin
    int exp23[6];
    int k;
    exp23 = '{0, 1, 2, 10, 11, 12};
    reset = 1'b1; start = 1'b0; m = 3'd0; n = 3'd0; matrix_in = '0;
    os.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // 2x3, elements 10*i+j, ready high then toggled
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        set_elem(i, j, 8'(10 * i + j));
    for (int pass = 0; pass < 2; pass++) begin
      got.delete();
      push_stream(2, 3);
      do_start(3'd2, 3'd3);
      @(negedge clk);
      chk("latency_valid", {31'd0, os.out_valid}, 32'd1);
      chk("busy_rise", {31'd0, busy}, 32'd1);
      wait_done(pass, 1'b0);
      chk("t23_count", got.size(), 32'd6);
      for (int i = 0; i < 6; i++) chk("t23_data", {24'd0, got[i]}, exp23[i]);
    end

    // illegal dimensions
    do_start(3'd0, 3'd3);
    @(negedge clk);
    chk("err_m0", {31'd0, err}, 32'd1);
    chk("err_m0_valid", {31'd0, os.out_valid}, 32'd0);
    chk("err_m0_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("err_m0_pulse", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    do_start(3'd6, 3'd2);
    @(negedge clk);
    chk("err_m6", {31'd0, err}, 32'd1);
    chk("err_m6_valid", {31'd0, os.out_valid}, 32'd0);
    chk("err_m6_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("err_m6_pulse", {31'd0, err}, 32'd0);
    @(posedge clk); #1;

    // 5x5 with an ignored start (and scrambled matrix_in) at beat 7
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        set_elem(i, j, 8'((i * 5 + j) * 7 + 3));
    got.delete();
    push_stream(5, 5);
    do_start(3'd5, 3'd5);
    wait_done(0, 1'b1);
    chk("t55_count", got.size(), 32'd25);
    chk("t55_beat7", {24'd0, got[7]}, 32'h34);
    chk("t55_beat24", {24'd0, got[24]}, 32'hAB);

    // 1x1
    matrix_in = '0;
    set_elem(0, 0, 8'hAB);
    got.delete();
    push_stream(1, 1);
    do_start(3'd1, 3'd1);
    wait_done(0, 1'b0);
    chk("t11_count", got.size(), 32'd1);
    chk("t11_data", {24'd0, got[0]}, 32'hAB);

    // 3x3 aborted by reset while beat 4 is presented
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        set_elem(i, j, 8'(16 * i + j + 1));
    got.delete();
    push_stream(3, 3);
    do_start(3'd3, 3'd3);
    k = 0;
    while (got.size() < 4 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk("abort_at_beat4", got.size(), 32'd4);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_vals("abort");
    expq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    @(posedge clk); #1;
    got.delete();
    push_stream(3, 3);
    do_start(3'd3, 3'd3);
    wait_done(0, 1'b0);
    chk("restart_count", got.size(), 32'd9);
    chk("restart_first", {24'd0, got[0]}, 32'h01);
    chk("restart_last", {24'd0, got[8]}, 32'h23);

`ifdef MATRIX_STREAM_HEADER_EN
    got.delete();
    push_stream(3, 4);
    do_start(3'd3, 3'd4);
    @(negedge clk);
    chk("hdr_flag", {31'd0, os.out_hdr}, 32'd1);
    chk("hdr_data", {24'd0, os.out_data}, 32'h23);
    wait_done(0, 1'b0);
    chk("hdr_elem_count", got.size(), 32'd12);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/matrix_stream_out.md
Name: matrix_stream_out

Overview:
- Reads a packed matrix bus (MAX_DIM x MAX_DIM elements, ELEM_W bits each, row-major) that the arithmetic units produce.
- Emits only the active m x n elements, one per beat, over a valid/ready stream.
- Serves as the consumer/reader end of the packed-matrix interface. Feeds display/UART output paths.
- Element (i,j) occupies bits [(i*MAX_DIM+j)*ELEM_W +: ELEM_W].

Parameters:
- ELEM_W, 8, element width in bits (must be >= 6).
- MAX_DIM, 5, maximum rows/cols; matrix bus width = MAX_DIM*MAX_DIM*ELEM_W (200 by default).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to stream the matrix currently on matrix_in.
- m  in  3  row count, legal 1..MAX_DIM.
- n  in  3  column count, legal 1..MAX_DIM.
- matrix_in  in  MAX_DIM*MAX_DIM*ELEM_W  packed source matrix.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle pulse when start is seen with illegal m/n.
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts the beat.
- out_data  out  ELEM_W  element value.
- out_row  out  3  row index of the beat.
- out_col  out  3  column index of the beat.
- out_hdr  out  1  beat is a header (see Optional Feature).
- out_last  out  1  final beat of the matrix.
- done  out  1  one-cycle pulse after the final beat transfers.

Behaviour:
- All outputs are registered. Reset values: busy=0, err=0, out_valid=0, out_data=0, out_row=0, out_col=0, out_hdr=0, out_last=0, done=0. FSM returns to IDLE.
- Reset has priority over everything else. Reset mid-stream aborts the stream: the next cycle shows the reset values and no done pulse is produced.
- States: IDLE, SEND, DONE; HEADER is added only when the macro is defined.
- IDLE:
  - start with m,n legal -> latch matrix_in, m, n; row=col=0; go to SEND (or HEADER).
  - start with m==0, n==0, m>MAX_DIM or n>MAX_DIM -> err=1 for the next cycle only; remain in IDLE.
- Latency: start sampled at edge k -> out_valid=1 with element (0,0) during cycle k+1.
- SEND:
  - out_valid=1. out_data = latched element(row,col); out_row=row; out_col=col.
  - out_last=1 iff row==m-1 and col==n-1.
  - A transfer occurs on a cycle with out_valid && out_ready.
  - No transfer -> all out_* hold stable.
  - On transfer:
    - col < n-1 -> col+1.
    - otherwise col=0 and row+1.
    - If the beat had out_last=1 -> go to DONE; out_valid drops the next cycle.
- DONE: done=1 for exactly one cycle, out_valid=0, then IDLE.
- start is ignored while busy=1, including in the DONE cycle. Changes on matrix_in, m or n while busy have no effect on the stream.
- Throughput is one beat per cycle when out_ready is held high. An m x n stream occupies m*n SEND cycles.
- Indices outside the active region are never emitted. Padding elements of matrix_in are never read.
- A 1x1 matrix is a single beat with out_last=1.

Optional Feature:
- Macro: MATRIX_STREAM_HEADER_EN.
- Defined:
  - A HEADER state sits between IDLE and SEND.
  - It emits one beat with out_hdr=1, out_row=0, out_col=0, out_last=0, and out_data = zero-extended {n[2:0], m[2:0]}.
  - It obeys the same hold-until-ready rule as SEND. After it transfers, the FSM enters SEND.
  - Start-to-first-element latency grows by the header handshake.
- Undefined: no HEADER state; out_hdr is tied to 0.

Test Plan:
- 2x3 matrix, elements (i,j)=10*i+j, out_ready=1 -> 6 consecutive beats 0,1,2,10,11,12. Rows/cols run 0,0..1,2. out_last only on value 12. done pulses 1 cycle after the last beat. busy falls with it.
- Same 2x3 stream with out_ready toggled 1,0,0,1,... -> no beat lost or duplicated. out_data/out_row/out_col stay stable during every stall.
- start with m=0,n=3, then with m=6,n=2 -> err pulses once per attempt. out_valid stays 0. busy stays 0.
- 5x5 stream; assert start with different dims at beat 7 -> ignored, and all 25 beats match the originally latched matrix. Then a 1x1 matrix with value 0xAB -> single beat 0xAB, out_last=1.
- reset asserted while streaming beat 4 of 3x3 -> next cycle every output at its reset value, no done pulse. A new start then streams normally from (0,0).
- With MATRIX_STREAM_HEADER_EN, stream m=3,n=4 -> first beat out_hdr=1, out_data=8'h23, then 12 element beats with out_hdr=0.
